// File: rtl/alu_op_scheduler_if.sv
// ---------------------------------------------------------------------------
// alu_op_scheduler_if
// Bundles every handshake/bus signal of alu_op_scheduler:
//   req0_* / req1_*  : two requester channels (valid/ready + sel, a, b, cnt)
//   rsp_*            : registered response channel (valid/ready + id, result, flags)
//   alu_*            : operand/select outputs to the external combinational ALU
//                      and its result/flag inputs
// Modports:
//   slave  : the scheduler itself
//   master : the surrounding environment (requesters, response consumer, ALU)
// ---------------------------------------------------------------------------
interface alu_op_scheduler_if #(
    parameter int W     = 8,
    parameter int CNT_W = 3
);
    // requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_sel;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic [CNT_W-1:0] req0_cnt;
    // requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_sel;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic [CNT_W-1:0] req1_cnt;
    // response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [W-1:0]     rsp_result;
    logic             rsp_zero;
    logic             rsp_neg;
    logic             rsp_carry;
    // external ALU
    logic [W-1:0]     alu_a;
    logic [W-1:0]     alu_b;
    logic [2:0]       alu_sel;
    logic [W-1:0]     alu_result;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_carry;

    modport slave (
        input  req0_valid, req0_sel, req0_a, req0_b, req0_cnt,
        output req0_ready,
        input  req1_valid, req1_sel, req1_a, req1_b, req1_cnt,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg, rsp_carry,
        input  rsp_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_zero, alu_neg, alu_carry
    );

    modport master (
        output req0_valid, req0_sel, req0_a, req0_b, req0_cnt,
        input  req0_ready,
        output req1_valid, req1_sel, req1_a, req1_b, req1_cnt,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_neg, rsp_carry,
        output rsp_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_zero, alu_neg, alu_carry
    );
endinterface

// File: rtl/alu_op_scheduler.sv
// ---------------------------------------------------------------------------
// alu_op_scheduler
// Shares one external combinational W-bit ALU between two requesters.
// Arbitrates, latches the granted op, drives the ALU operand/select inputs,
// iterates shift ops (sel 011 / 100) for max(cnt,1) passes and returns a
// registered result plus flags over a valid/ready response channel.
//
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous, active-high reset
//   bus   : alu_op_scheduler_if.slave (requesters, response, ALU)
//   busy  : high whenever an op is in flight (state != IDLE)
//
// Build option:
//   ALU_SCHED_FIXED_PRIO_EN defined -> fixed priority, req0 always wins a tie
//                                      (req1 may starve).
//   undefined (default)            -> round-robin on the last served id.
// ---------------------------------------------------------------------------
module alu_op_scheduler #(
    parameter int W     = 8,
    parameter int CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    alu_op_scheduler_if.slave   bus,
    output logic                busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0]       SEL_SHL = 3'b011;
    localparam logic [2:0]       SEL_SHR = 3'b100;
    localparam logic [CNT_W-1:0] REM_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             op_id_q, op_id_d;
    logic [W-1:0]     res_q, res_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             carry_q, carry_d;
    logic             rsp_id_q, rsp_id_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
    logic             ptr_q, ptr_d;   // id of the last requester whose response was taken
`endif

    // Grant selection and operand mux
    logic             any_valid;
    logic             grant_id;
    logic [2:0]       g_sel;
    logic [W-1:0]     g_a;
    logic [W-1:0]     g_b;
    logic [CNT_W-1:0] g_cnt;

    always_comb begin
        // Readies must stay low while reset is asserted, so requests are not
        // granted during a reset cycle.
        any_valid = (bus.req0_valid || bus.req1_valid) && !rst;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        grant_id  = !bus.req0_valid;
`else
        // On a tie the requester that was not served last wins.
        grant_id  = (bus.req0_valid && bus.req1_valid) ? ~ptr_q : bus.req1_valid;
`endif
        g_sel = grant_id ? bus.req1_sel : bus.req0_sel;
        g_a   = grant_id ? bus.req1_a   : bus.req0_a;
        g_b   = grant_id ? bus.req1_b   : bus.req0_b;
        g_cnt = grant_id ? bus.req1_cnt : bus.req0_cnt;
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        op_id_d  = op_id_q;
        res_d    = res_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        carry_d  = carry_q;
        rsp_id_d = rsp_id_q;
`ifndef ALU_SCHED_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_sel    = '0;

        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    bus.req0_ready = !grant_id;
                    bus.req1_ready = grant_id;
                    sel_d   = g_sel;
                    a_d     = g_a;
                    b_d     = g_b;
                    op_id_d = grant_id;
                    // Shifts run one ALU pass per position; a count of 0
                    // still takes one pass. Other selects take one pass.
                    if (g_sel == SEL_SHL || g_sel == SEL_SHR) begin
                        rem_d = (g_cnt == '0) ? REM_ONE : g_cnt;
                    end else begin
                        rem_d = REM_ONE;
                    end
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                bus.alu_a   = a_q;
                bus.alu_b   = b_q;
                bus.alu_sel = sel_q;
                if (rem_q > REM_ONE) begin
                    // Feed the partial shift back as the next pass's operand A.
                    a_d   = bus.alu_result;
                    rem_d = rem_q - REM_ONE;
                end else begin
                    res_d    = bus.alu_result;
                    zero_d   = bus.alu_zero;
                    neg_d    = bus.alu_neg;
                    carry_d  = bus.alu_carry;
                    rsp_id_d = op_id_q;
                    rem_d    = '0;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
`ifndef ALU_SCHED_FIXED_PRIO_EN
                    ptr_d = rsp_id_q;
`endif
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            op_id_q  <= 1'b0;
            res_q    <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            carry_q  <= 1'b0;
            rsp_id_q <= 1'b0;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q    <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            op_id_q  <= op_id_d;
            res_q    <= res_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            carry_q  <= carry_d;
            rsp_id_q <= rsp_id_d;
`ifndef ALU_SCHED_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_neg    = neg_q;
    assign bus.rsp_carry  = carry_q;
    assign busy           = (state_q != ST_IDLE);

endmodule
